// File: rtl/kyber_zeta_fetch_if.sv
// Bundles the command, ROM and zeta-stream signals of the zeta fetch unit.
// Latency: none; this interface only groups signals.
// Backpressure: z_valid/z_ready on the stream, cmd_valid/cmd_ready on commands.
interface kyber_zeta_fetch_if;
    // command side (Kyber control FSM)
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_start;
    logic [8:0]  cmd_count;
    logic        cmd_dir;
    logic [7:0]  cmd_rep;
    // zeta ROM side
    logic [7:0]  rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [11:0] rom_dout;
    // zeta stream side (butterfly unit)
    logic        z_valid;
    logic        z_ready;
    logic [11:0] z_data;
    logic [7:0]  z_addr;
    logic        z_last;
    logic        done;

    // fetch engine view
    modport master (
        input  cmd_valid, cmd_start, cmd_count, cmd_dir, cmd_rep, rom_dout, z_ready,
        output cmd_ready, rom_ad, rom_ce, rom_oce, rom_reset,
               z_valid, z_data, z_addr, z_last, done
    );

    // environment view (control FSM, ROM, butterfly)
    modport slave (
        output cmd_valid, cmd_start, cmd_count, cmd_dir, cmd_rep, rom_dout, z_ready,
        input  cmd_ready, rom_ad, rom_ce, rom_oce, rom_reset,
               z_valid, z_data, z_addr, z_last, done
    );
endinterface

// File: rtl/kyber_zeta_fetch.sv
// Reads the 256x12 zeta ROM per command and streams each zeta rep times.
// Latency: command accepted in T -> first ROM read T+1 -> first z_valid T+3.
// Backpressure: z_ready stalls the head; reads throttle so the 2-entry FIFO never overflows.
module kyber_zeta_fetch (
    input  logic               clk,
    input  logic               reset,
    kyber_zeta_fetch_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ad_q, ad_d;
    logic [8:0]  reads_left_q, reads_left_d;
    logic [8:0]  pops_left_q, pops_left_d;
    logic        dir_q, dir_d;
    logic [7:0]  rep_q, rep_d;
    logic [7:0]  rep_cnt_q, rep_cnt_d;

    // one-deep record of the read whose data returns next cycle
    logic        inflight_q;
    logic [7:0]  inflight_ad_q;

    // 2-entry return FIFO holding {data, address}
    logic [11:0] fifo_dat_q [2];
    logic [7:0]  fifo_ad_q  [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  fifo_cnt_q;

    logic        cmd_fire, ce, emit, pop, last_rep, final_emit, vld;
    logic [2:0]  occ;

    assign vld        = (fifo_cnt_q != 2'd0);
    assign emit       = vld & bus.z_ready;
    assign last_rep   = (rep_cnt_q == rep_q - 8'd1);
    assign pop        = emit & last_rep;
    assign final_emit = pop & (pops_left_q == 9'd1);
    assign cmd_fire   = bus.cmd_valid & bus.cmd_ready;

    // occupancy after this cycle's pop; a new read is allowed only if its data will fit
    assign occ = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign ce  = (state_q == S_FETCH) && (reads_left_q != 9'd0) && (occ < 3'd2);

    assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
    assign bus.rom_ad    = ad_q;
    assign bus.rom_ce    = ce;
    assign bus.rom_oce   = 1'b1;
    assign bus.rom_reset = reset;
    assign bus.z_valid   = vld;
    assign bus.z_data    = fifo_dat_q[rd_ptr_q];
    assign bus.z_addr    = fifo_ad_q[rd_ptr_q];
    assign bus.z_last    = vld & last_rep & (pops_left_q == 9'd1);
    assign bus.done      = (state_q == S_DONE);

    // next-state, command latching, address walk and repeat counting
    always_comb begin
        state_d      = state_q;
        ad_d         = ad_q;
        reads_left_d = reads_left_q;
        pops_left_d  = pops_left_q;
        dir_d        = dir_q;
        rep_d        = rep_q;
        rep_cnt_d    = rep_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    ad_d         = bus.cmd_start;
                    reads_left_d = bus.cmd_count;
                    pops_left_d  = bus.cmd_count;
                    dir_d        = bus.cmd_dir;
                    rep_d        = (bus.cmd_rep == 8'd0) ? 8'd1 : bus.cmd_rep;
                    rep_cnt_d    = 8'd0;
                    state_d      = (bus.cmd_count == 9'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: if (ce && reads_left_q == 9'd1) state_d = S_DRAIN;
            S_DRAIN: if (final_emit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ce) begin
            ad_d         = dir_q ? (ad_q - 8'd1) : (ad_q + 8'd1);
            reads_left_d = reads_left_q - 9'd1;
        end
        if (emit) rep_cnt_d = last_rep ? 8'd0 : (rep_cnt_q + 8'd1);
        if (pop)  pops_left_d = pops_left_q - 9'd1;
    end

    // control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ad_q         <= 8'd0;
            reads_left_q <= 9'd0;
            pops_left_q  <= 9'd0;
            dir_q        <= 1'b0;
            rep_q        <= 8'd0;
            rep_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            ad_q         <= ad_d;
            reads_left_q <= reads_left_d;
            pops_left_q  <= pops_left_d;
            dir_q        <= dir_d;
            rep_q        <= rep_d;
            rep_cnt_q    <= rep_cnt_d;
        end
    end

    // ROM return capture into the FIFO; reset drops any read still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q    <= 1'b0;
            inflight_ad_q <= 8'd0;
            fifo_dat_q[0] <= 12'd0;
            fifo_dat_q[1] <= 12'd0;
            fifo_ad_q[0]  <= 8'd0;
            fifo_ad_q[1]  <= 8'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            inflight_q <= ce;
            if (ce) inflight_ad_q <= ad_q;
            if (inflight_q) begin
                fifo_dat_q[wr_ptr_q] <= bus.rom_dout;
                fifo_ad_q[wr_ptr_q]  <= inflight_ad_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_kyber_zeta_fetch.sv
// Directed bench for kyber_zeta_fetch with a behavioural zeta ROM (zeta[i] = 17^i mod 3329).
// Latency: checks T+1 read, T+3 first output, done one cycle after the last handshake.
// Backpressure: exercises toggling z_ready and checks outputs hold while stalled.
module tb_kyber_zeta_fetch;
    logic clk;
    logic reset;
    kyber_zeta_fetch_if zif();

    kyber_zeta_fetch dut (.clk(clk), .reset(reset), .bus(zif));

    int n_assert = 0;
    int n_fail   = 0;
    int ztab [256];

    logic [11:0] got_dat  [$];
    logic [7:0]  got_ad   [$];
    logic        got_last [$];
    int          got_cyc  [$];
    int first_ce, first_vld, done_cyc, ce_cnt, stalls, stall_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ROM: one-cycle read latency
    initial zif.rom_dout = 12'd0;
    always @(posedge clk) if (zif.rom_ce) zif.rom_dout <= 12'(ztab[zif.rom_ad]);

    // the return FIFO must never exceed two entries
    always @(negedge clk) begin
        if (!reset) begin
            n_assert++;
            assert (dut.fifo_cnt_q <= 2'd2) else begin
                n_fail++;
                $error("FAIL fifo_overflow: observed %0d required <= 2", dut.fifo_cnt_q);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // issue one command and record every emission until done (bounded)
    task automatic run_cmd(input string tag, input logic [7:0] st, input logic [8:0] cnt,
                           input logic d, input logic [7:0] rp, input bit toggle);
        bit          rdy;
        bit          held;
        logic [11:0] hd;
        logic [7:0]  ha;
        logic        hl;
        got_dat.delete(); got_ad.delete(); got_last.delete(); got_cyc.delete();
        first_ce = -1; first_vld = -1; done_cyc = -1; ce_cnt = 0; stalls = 0; stall_bad = 0;
        held = 1'b0; rdy = 1'b1; hd = '0; ha = '0; hl = 1'b0;
        @(posedge clk); #1;
        zif.cmd_valid = 1'b1; zif.cmd_start = st; zif.cmd_count = cnt;
        zif.cmd_dir = d; zif.cmd_rep = rp; zif.z_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_cmd_ready"}, 32'(zif.cmd_ready), 32'd1);
        @(posedge clk); #1;
        zif.cmd_valid = 1'b0;
        for (int k = 1; k <= 700 && done_cyc < 0; k++) begin
            zif.z_ready = toggle ? rdy : 1'b1;
            @(negedge clk);
            if (zif.rom_ce) begin
                ce_cnt++;
                if (first_ce < 0) first_ce = k;
            end
            if (zif.z_valid && first_vld < 0) first_vld = k;
            if (held && (!zif.z_valid || zif.z_data !== hd || zif.z_addr !== ha || zif.z_last !== hl))
                stall_bad++;
            held = zif.z_valid && !zif.z_ready;
            if (held) stalls++;
            hd = zif.z_data; ha = zif.z_addr; hl = zif.z_last;
            if (zif.z_valid && zif.z_ready) begin
                got_dat.push_back(zif.z_data);
                got_ad.push_back(zif.z_addr);
                got_last.push_back(zif.z_last);
                got_cyc.push_back(k);
            end
            if (zif.done) done_cyc = k;
            @(posedge clk); #1;
            rdy = !rdy;
        end
        chk({tag, "_done_seen"}, 32'(done_cyc > 0), 32'd1);
        @(negedge clk);
        chk({tag, "_ready_after_done"}, 32'(zif.cmd_ready), 32'd1);
        chk({tag, "_done_one_pulse"}, 32'(zif.done), 32'd0);
    endtask

    // compare the recorded stream against the expected address walk
    task automatic check_seq(input string tag, input int st, input int cnt, input bit d, input int rp);
        int bad_ad;
        int bad_dat;
        int bad_last;
        int z;
        int a;
        bad_ad = 0; bad_dat = 0; bad_last = 0;
        chk({tag, "_len"}, 32'(got_dat.size()), 32'(cnt * rp));
        for (int i = 0; i < got_dat.size(); i++) begin
            z = i / rp;
            a = d ? ((st - z) & 255) : ((st + z) & 255);
            if (got_ad[i] !== 8'(a)) bad_ad++;
            if (got_dat[i] !== 12'(ztab[a])) bad_dat++;
            if (got_last[i] !== (i == cnt * rp - 1)) bad_last++;
        end
        chk({tag, "_addr_errs"}, 32'(bad_ad), 32'd0);
        chk({tag, "_data_errs"}, 32'(bad_dat), 32'd0);
        chk({tag, "_last_errs"}, 32'(bad_last), 32'd0);
    endtask

    initial begin
        int p;
        p = 1;
        for (int i = 0; i < 256; i++) begin
            ztab[i] = p;
            p = (p * 17) % 3329;
        end
        reset = 1'b1;
        zif.cmd_valid = 1'b0; zif.cmd_start = 8'd0; zif.cmd_count = 9'd0;
        zif.cmd_dir = 1'b0; zif.cmd_rep = 8'd0; zif.z_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(zif.cmd_ready), 32'd0);
        chk("rst_rom_reset", 32'(zif.rom_reset), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(zif.cmd_ready), 32'd1);
        chk("idle_rom_ce",    32'(zif.rom_ce),    32'd0);
        chk("idle_rom_ad",    32'(zif.rom_ad),    32'd0);
        chk("idle_rom_oce",   32'(zif.rom_oce),   32'd1);
        chk("idle_rom_reset", 32'(zif.rom_reset), 32'd0);
        chk("idle_z_valid",   32'(zif.z_valid),   32'd0);
        chk("idle_z_last",    32'(zif.z_last),    32'd0);
        chk("idle_done",      32'(zif.done),      32'd0);
        chk("idle_z_data",    32'(zif.z_data),    32'd0);
        chk("idle_z_addr",    32'(zif.z_addr),    32'd0);

        // NTT sweep
        run_cmd("ntt", 8'd1, 9'd127, 1'b0, 8'd1, 1'b0);
        chk("ntt_first_ce",  32'(first_ce),  32'd1);
        chk("ntt_first_vld", 32'(first_vld), 32'd3);
        chk("ntt_first_cyc", 32'(got_cyc[0]), 32'd3);
        chk("ntt_no_bubble", 32'(got_cyc[got_cyc.size()-1] - got_cyc[0]), 32'd126);
        chk("ntt_dat0",  32'(got_dat[0]), 32'h011);
        chk("ntt_ad0",   32'(got_ad[0]),  32'd1);
        chk("ntt_dat1",  32'(got_dat[1]), 32'h121);
        chk("ntt_datN",  32'(got_dat[got_dat.size()-1]), 32'h86A);
        chk("ntt_adN",   32'(got_ad[got_ad.size()-1]),   32'd127);
        chk("ntt_lastN", 32'(got_last[got_last.size()-1]), 32'd1);
        chk("ntt_done_cyc", 32'(done_cyc), 32'(got_cyc[got_cyc.size()-1] + 1));
        check_seq("ntt", 1, 127, 1'b0, 1);

        // INTT sweep
        run_cmd("intt", 8'd127, 9'd127, 1'b1, 8'd1, 1'b0);
        chk("intt_dat0", 32'(got_dat[0]), 32'h86A);
        chk("intt_datN", 32'(got_dat[got_dat.size()-1]), 32'h011);
        chk("intt_adN",  32'(got_ad[got_ad.size()-1]),   32'd1);
        check_seq("intt", 127, 127, 1'b1, 1);

        // repeat with toggling backpressure
        run_cmd("rep", 8'd2, 9'd2, 1'b0, 8'd3, 1'b1);
        chk("rep_dat0", 32'(got_dat[0]), 32'h121);
        chk("rep_dat2", 32'(got_dat[2]), 32'h121);
        chk("rep_dat3", 32'(got_dat[3]), 32'h630);
        chk("rep_dat5", 32'(got_dat[5]), 32'h630);
        chk("rep_saw_stall", 32'(stalls > 0), 32'd1);
        chk("rep_stall_stable", 32'(stall_bad), 32'd0);
        chk("rep_done_cyc", 32'(done_cyc), 32'(got_cyc[got_cyc.size()-1] + 1));
        check_seq("rep", 2, 2, 1'b0, 3);

        // address wrap
        run_cmd("wrap", 8'd255, 9'd3, 1'b0, 8'd1, 1'b0);
        chk("wrap_ad0",  32'(got_ad[0]),  32'd255);
        chk("wrap_ad1",  32'(got_ad[1]),  32'd0);
        chk("wrap_ad2",  32'(got_ad[2]),  32'd1);
        chk("wrap_dat0", 32'(got_dat[0]), 32'h497);
        chk("wrap_dat1", 32'(got_dat[1]), 32'h001);
        chk("wrap_dat2", 32'(got_dat[2]), 32'h011);
        check_seq("wrap", 255, 3, 1'b0, 1);

        // count = 0
        run_cmd("cnt0", 8'd9, 9'd0, 1'b0, 8'd1, 1'b0);
        chk("cnt0_done_cyc", 32'(done_cyc),  32'd1);
        chk("cnt0_ce",       32'(ce_cnt),    32'd0);
        chk("cnt0_no_vld",   32'(first_vld), 32'hFFFF_FFFF);

        // rep = 0 acts as rep = 1
        run_cmd("rep0", 8'd4, 9'd3, 1'b0, 8'd0, 1'b0);
        check_seq("rep0", 4, 3, 1'b0, 1);

        // full 256-entry descending sweep wrapping past 0
        run_cmd("full", 8'd200, 9'd256, 1'b1, 8'd1, 1'b0);
        chk("full_ce", 32'(ce_cnt), 32'd256);
        check_seq("full", 200, 256, 1'b1, 1);

        // reset while FETCH holds one FIFO entry and one read in flight
        @(posedge clk); #1;
        zif.cmd_valid = 1'b1; zif.cmd_start = 8'd10; zif.cmd_count = 9'd50;
        zif.cmd_dir = 1'b0; zif.cmd_rep = 8'd1; zif.z_ready = 1'b0;
        @(posedge clk); #1;
        zif.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_z_valid",  32'(zif.z_valid),      32'd1);
        chk("mid_fifo_cnt", 32'(dut.fifo_cnt_q),   32'd1);
        chk("mid_inflight", 32'(dut.inflight_q),   32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_z_valid",   32'(zif.z_valid),   32'd0);
        chk("post_rst_cmd_ready", 32'(zif.cmd_ready), 32'd1);
        chk("post_rst_rom_ce",    32'(zif.rom_ce),    32'd0);
        run_cmd("after_rst", 8'd5, 9'd4, 1'b0, 8'd1, 1'b0);
        chk("after_rst_first_vld", 32'(first_vld), 32'd3);
        check_seq("after_rst", 5, 4, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/kyber_zeta_fetch.md
# kyber_zeta_fetch

Command-driven reader for the Kyber 256×12 zeta ROM. It generates ROM addresses (ascending or descending, modulo 256) and absorbs the ROM's one-cycle read latency. Each fetched zeta is delivered on a valid/ready stream and repeated a programmable number of times, so the NTT, INTT and basemul butterfly datapaths can consume twiddles without tracking ROM timing. It sits between the Kyber control FSM (command side) and the butterfly unit (stream side).

## Interface
- No parameters; widths fixed: ROM address 8 bits, data 12 bits, FIFO depth 2.
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_start  in  8  first ROM address
- cmd_count  in  9  number of distinct zetas to fetch, 0..256
- cmd_dir  in  1  0 = address +1 per fetch, 1 = address −1 per fetch (mod 256)
- cmd_rep  in  8  emissions per zeta; 0 treated as 1
- rom_ad  out  8  ROM address
- rom_ce  out  1  ROM read enable (one read per asserted cycle)
- rom_oce  out  1  tied 1
- rom_reset  out  1  equals reset
- rom_dout  in  12  ROM data, valid the cycle after rom_ce
- z_valid  out  1  zeta available
- z_ready  in  1  consumer accept
- z_data  out  12  zeta value
- z_addr  out  8  ROM address z_data came from
- z_last  out  1  final emission of the command
- done  out  1  one-cycle pulse when command fully consumed

## Operation
- States: IDLE, FETCH, DRAIN, DONE. Transitions:
  - IDLE→FETCH on cmd_valid & cmd_ready. Latch start, count, dir and rep (rep = max(cmd_rep, 1)).
  - IDLE→DONE when the accepted count = 0. No ROM reads and no emissions occur.
  - FETCH→DRAIN in the cycle the last read issues.
  - DRAIN→DONE when FIFO empty, nothing in flight, and the final emission is accepted.
  - DONE→IDLE unconditionally.
- Read issue: rom_ce = 1 in FETCH when reads_left > 0 and (fifo_count + inflight − pop) < 2.
  - pop = z_valid & z_ready & (rep_cnt == rep−1).
  - This gives full throughput when z_ready stays high.
- Address advance: rom_ad holds the next address. After each issue it becomes ad ± 1 (8-bit wrap: 255+1 = 0, 0−1 = 255).
- Return path: the cycle after rom_ce, rom_dout and its address are written into the 2-entry FIFO. The FIFO can never overflow by construction; the bench asserts this.
- Output: z_valid = FIFO non-empty. z_data and z_addr come from the FIFO head.
- Repeats: rep_cnt counts accepted emissions of the head entry. The head pops at rep_cnt = rep−1, then rep_cnt resets to 0.
- z_last = z_valid on the final zeta of the command at its final repeat.
- A command with count = 256 reads all addresses once; the sequence wraps past 255/0 as needed.
- Outputs are stable while z_valid & !z_ready.

## Timing
- Reset values: cmd_ready 0 during reset then 1 (IDLE); rom_ce 0; rom_ad 0; z_valid 0; z_last 0; done 0; FIFO, counters and inflight cleared. z_data/z_addr are 0.
- Command handshake in cycle T:
  - First rom_ce in T+1.
  - rom_dout sampled at end of T+2.
  - First z_valid in T+3.
- Steady state with z_ready = 1 and rep = 1: one zeta per cycle, no bubbles.
- Completion: done pulses the cycle after the z_last handshake. cmd_ready returns 1 the following cycle.
- For count = 0 accepted in T: done in T+1, cmd_ready in T+2.
- Reset mid-command: the next cycle is IDLE with everything cleared. An in-flight ROM read is discarded.
- cmd_* inputs are ignored outside IDLE.

## Test plan
- NTT sweep: start=1, count=127, dir=0, rep=1, z_ready=1.
  - Required: 127 outputs on consecutive cycles from T+3.
  - First z_data = 0x011 (addr 1), second 0x121 (addr 2), last 0x86A (addr 127) with z_last = 1.
  - done one cycle after the last output.
- INTT sweep: start=127, count=127, dir=1, rep=1.
  - Required: first 0x86A, last 0x011 at addr 1, z_addr strictly decreasing.
- Repeat plus backpressure: start=2, count=2, rep=3, z_ready toggling 1,0,1,0…
  - Required: exactly 0x121 ×3 then addr 3 data ×3.
  - Values held stable while stalled; z_last only on the 6th emission.
- Wrap: start=255, count=3, dir=0.
  - Required: z_addr 255, 0, 1 with data 0x497, 0x001, 0x011.
- Degenerate commands:
  - count=0 → no rom_ce, no z_valid, done at T+1.
  - rep=0 → behaves as rep=1.
- Reset mid-stream: assert reset during FETCH with 1 entry in FIFO and 1 read in flight.
  - Required: next cycle z_valid = 0 and cmd_ready = 1. A new command then produces correct data with no stale entries.
